// File: rtl/microcode_sequencer.sv
// Microcode sequencer: byte-loaded writable control store plus opcode / micro-op / condition
// sequencing state. Drives the per-cycle control word to control_logic.
module microcode_sequencer #(
  parameter int unsigned OPCODE_BITS = 6,
  parameter int unsigned UOP_BITS    = 5,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned BOOT_WIDTH  = 8,
  parameter int unsigned NUM_COND    = 4,
  parameter int unsigned RST_BIT     = 17,
  parameter int unsigned INPLANE_LSB = 14,
  parameter int unsigned IN_OPCODE   = 6,
  parameter int unsigned OPSEL_BIT   = 25,
  parameter int unsigned CSEL_LSB    = 26
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  STALL,
  input  logic [OPCODE_BITS-1:0]                OPWORD_OPCODE,
  input  logic [OPCODE_BITS-1:0]                BUS_OPCODE,
  input  logic [NUM_COND-1:0]                   COND,
  input  logic                                  BOOT_WE,
  input  logic [BOOT_WIDTH-1:0]                 BOOT_DATA,
  input  logic                                  BOOT_DONE,
  output logic [WORD_WIDTH-1:0]                 OUT,
  output logic [1+OPCODE_BITS+UOP_BITS-1:0]     UADDR,
  output logic                                  BOOTED,
  output logic                                  FAULT
);

  localparam int unsigned ADDR_BITS = 1 + OPCODE_BITS + UOP_BITS;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam int unsigned LANES     = WORD_WIDTH / BOOT_WIDTH;
  localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CSEL_BITS = (NUM_COND > 1) ? $clog2(NUM_COND) : 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   boot_addr_q, boot_addr_d;
  logic [LANE_BITS-1:0]   lane_q, lane_d;
  logic [WORD_WIDTH-1:0]  asm_q, asm_d;
  logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
  logic [UOP_BITS-1:0]    count_q, count_d;
  logic                   cond_q, cond_d;
  logic                   store_we;
  logic [WORD_WIDTH-1:0]  store_wdata;
  logic [ADDR_BITS-1:0]   uaddr;
  logic [WORD_WIDTH-1:0]  word_c;
  logic [CSEL_BITS-1:0]   csel;

  // Control store; deliberately not reset so a warm reset keeps the loaded microcode.
  logic [WORD_WIDTH-1:0]  store [DEPTH];

  assign uaddr  = {cond_q, opcode_q, count_q};
  assign word_c = store[uaddr];
  assign csel   = word_c[CSEL_LSB +: CSEL_BITS];

  assign OUT    = (state_q == ST_RUN) ? word_c : '0;
  assign UADDR  = uaddr;
  assign BOOTED = (state_q != ST_BOOT);
  assign FAULT  = (state_q == ST_FAULT);

  // Store write port, gated by reset so an aborted boot cannot land a word.
  always_ff @(posedge CLK) begin
    if (store_we && !RST) store[boot_addr_q] <= store_wdata;
  end

  // State and sequencing registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_BOOT;
      boot_addr_q <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      opcode_q    <= '0;
      count_q     <= '0;
      cond_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_addr_q <= boot_addr_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      opcode_q    <= opcode_d;
      count_q     <= count_d;
      cond_q      <= cond_d;
    end
  end

  // Next state: byte assembly during boot, micro-op sequencing during run.
  always_comb begin
    state_d     = state_q;
    boot_addr_d = boot_addr_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    opcode_d    = opcode_q;
    count_d     = count_q;
    cond_d      = cond_q;
    store_we    = 1'b0;
    store_wdata = '0;
    case (state_q)
      ST_BOOT: begin
        if (BOOT_WE) begin
          asm_d[int'(lane_q) * BOOT_WIDTH +: BOOT_WIDTH] = BOOT_DATA;
          if (lane_q == LANE_BITS'(LANES - 1)) begin
            store_we    = 1'b1;
            store_wdata = asm_d;
            boot_addr_d = boot_addr_q + ADDR_BITS'(1);
            lane_d      = '0;
            asm_d       = '0;
          end else begin
            lane_d = lane_q + LANE_BITS'(1);
          end
        end
        // Done is handled after any same-cycle byte; a partial word is flushed zero-padded.
        if (BOOT_DONE) begin
          if (lane_d != '0) begin
            store_we    = 1'b1;
            store_wdata = asm_d;
            boot_addr_d = boot_addr_q + ADDR_BITS'(1);
          end
          lane_d   = '0;
          asm_d    = '0;
          opcode_d = '0;
          count_d  = '0;
          cond_d   = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!STALL) begin
          if (!word_c[RST_BIT] && (count_q == {UOP_BITS{1'b1}})) begin
            state_d = ST_FAULT;
          end else begin
            count_d = word_c[RST_BIT] ? '0 : count_q + UOP_BITS'(1);
            if (word_c[INPLANE_LSB +: 3] == 3'(IN_OPCODE))
              opcode_d = word_c[OPSEL_BIT] ? BUS_OPCODE : OPWORD_OPCODE;
            cond_d = (32'(csel) < NUM_COND) ? COND[csel] : 1'b0;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: vector table, directed sequences, random run vs model.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [5:0]  opword_opcode;
  logic [5:0]  bus_opcode;
  logic [3:0]  cond;
  logic        boot_we;
  logic [7:0]  boot_data;
  logic        boot_done;
  logic [31:0] out;
  logic [11:0] uaddr;
  logic        booted;
  logic        fault;

  microcode_sequencer dut (
    .CLK(clk), .RST(rst), .STALL(stall),
    .OPWORD_OPCODE(opword_opcode), .BUS_OPCODE(bus_opcode), .COND(cond),
    .BOOT_WE(boot_we), .BOOT_DATA(boot_data), .BOOT_DONE(boot_done),
    .OUT(out), .UADDR(uaddr), .BOOTED(booted), .FAULT(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: whole-word store image plus sequencing variables as integers.
  logic [31:0] m_store [4096];
  int m_mode;   // 0 boot, 1 run, 2 fault
  int m_op, m_cnt, m_cond, m_baddr;

  typedef struct {
    logic        rst;
    logic        we;
    logic        done;
    logic [7:0]  data;
    logic [11:0] e_uaddr;
    logic [31:0] e_out;
    logic        e_booted;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] m_uaddr();
    return 12'(m_cond * 2048 + m_op * 32 + m_cnt);
  endfunction

  function automatic logic [31:0] m_out();
    return (m_mode == 1) ? m_store[m_uaddr()] : 32'h0;
  endfunction

  // Expect RUN state at the given address with the given control word.
  task automatic run_exp(input string name, input int ua, input logic [31:0] o);
    chk(name, {18'h0, uaddr, out, booted, fault}, {18'h0, 12'(ua), o, 1'b1, 1'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_mode = 0; m_op = 0; m_cnt = 0; m_cond = 0; m_baddr = 0;
  endtask

  task automatic boot_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      boot_we   = 1'b1;
      boot_data = 8'(w >> (8 * i));
      tick();
      if (gaps && ($urandom % 4 == 0)) begin
        boot_we = 1'b0;
        tick();
      end
    end
    boot_we = 1'b0;
    m_store[m_baddr] = w;
    m_baddr = (m_baddr + 1) % 4096;
    chk("boot_idle", {30'h0, out, booted, fault}, 64'h0);
  endtask

  // One clock with the currently driven inputs; model advances by the specification's rules.
  task automatic cycle();
    logic [31:0] w;
    int r;
    if (rst) begin
      m_mode = 0; m_op = 0; m_cnt = 0; m_cond = 0; m_baddr = 0;
    end else if (m_mode == 0) begin
      if (boot_done) begin
        m_mode = 1; m_op = 0; m_cnt = 0; m_cond = 0;
      end
    end else if (m_mode == 1 && !stall) begin
      w = m_store[m_uaddr()];
      r = int'((w >> 17) & 32'h1);
      if (r == 0 && m_cnt == 31) begin
        m_mode = 2;
      end else begin
        if (((w >> 14) & 32'h7) == 32'h6)
          m_op = ((w >> 25) & 32'h1) != 0 ? int'(bus_opcode) : int'(opword_opcode);
        m_cond = int'(cond[int'((w >> 26) & 32'h3)]);
        m_cnt  = (r != 0) ? 0 : m_cnt + 1;
      end
    end
    tick();
  endtask

  // Directed microcode image: reset op, fetch op 1, op 3 (with BEQ target), op 5 without count reset.
  function automatic logic [31:0] img(input int a);
    if (a == 0) return 32'h0203_8000;
    if (a >= 32 && a <= 35) return 32'h0000_1000 + 32'(a - 32);
    if (a == 36) return 32'h0003_8000;
    if (a >= 96 && a <= 98) return 32'h0000_3000 + 32'(a - 96);
    if (a == 99) return 32'h0003_8003;
    if (a >= 160 && a <= 191) return 32'h0000_5000 + 32'(a - 160);
    if (a >= 2144 && a <= 2146) return 32'h8000_3000 + 32'(a - 2144);
    if (a == 2147) return 32'h8003_8003;
    return 32'h0;
  endfunction

  function automatic vec_t mk(input logic r, input logic we, input logic dn, input logic [7:0] d,
                              input logic [11:0] ua, input logic [31:0] o, input logic b);
    vec_t v;
    v.rst = r; v.we = we; v.done = dn; v.data = d;
    v.e_uaddr = ua; v.e_out = o; v.e_booted = b;
    return v;
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; opword_opcode = '0; bus_opcode = '0; cond = '0;
    boot_we = 1'b0; boot_data = '0; boot_done = 1'b0;
    m_mode = 0; m_op = 0; m_cnt = 0; m_cond = 0; m_baddr = 0;

    // Vector table: word assembly LSB lane first, consecutive boot addresses, first run cycles.
    tbl[0]  = mk(1, 0, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[1]  = mk(0, 1, 0, 8'h01, 12'd0, 32'h0, 0);
    tbl[2]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[3]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[4]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[5]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[6]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[7]  = mk(0, 1, 0, 8'h02, 12'd0, 32'h0, 0);
    tbl[8]  = mk(0, 1, 0, 8'h00, 12'd0, 32'h0, 0);
    tbl[9]  = mk(0, 0, 1, 8'h00, 12'd0, 32'h0000_0001, 1);
    tbl[10] = mk(0, 0, 0, 8'h00, 12'd1, 32'h0002_0000, 1);
    tbl[11] = mk(0, 0, 0, 8'h00, 12'd0, 32'h0000_0001, 1);
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; boot_we = tbl[i].we; boot_done = tbl[i].done; boot_data = tbl[i].data;
      tick();
      chk($sformatf("vec%0d", i), {18'h0, uaddr, out, booted, fault},
          {18'h0, tbl[i].e_uaddr, tbl[i].e_out, tbl[i].e_booted, 1'b0});
    end
    rst = 1'b0; boot_we = 1'b0; boot_done = 1'b0;

    // Directed image boot, then fetch / BEQ / stall / overflow sequences.
    do_reset();
    for (int a = 0; a < 2148; a++) boot_word(img(a), 1'b0);
    bus_opcode = 6'd1; opword_opcode = 6'd3; cond = 4'h0;
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    run_exp("run_entry", 0, 32'h0203_8000);
    tick(); run_exp("fetch_c0", 32, 32'h0000_1000);
    for (int c = 1; c < 4; c++) begin
      tick(); run_exp("fetch_cn", 32 + c, 32'h0000_1000 + 32'(c));
    end
    tick(); run_exp("fetch_c4", 36, 32'h0003_8000);
    tick(); run_exp("after_fetch", 96, 32'h0000_3000);
    tick(); run_exp("op3_c1", 97, 32'h0000_3001);
    tick(); run_exp("op3_c2", 98, 32'h0000_3002);
    cond = 4'h1; tick(); cond = 4'h0;
    run_exp("beq_taken", 2147, 32'h8003_8003);
    tick(); run_exp("beq_return", 96, 32'h0000_3000);
    tick(); tick(); run_exp("op3_c2b", 98, 32'h0000_3002);
    tick(); run_exp("beq_not_taken", 99, 32'h0003_8003);
    tick(); tick(); tick(); run_exp("pre_stall", 98, 32'h0000_3002);
    stall = 1'b1; cond = 4'hF;
    for (int s = 0; s < 3; s++) begin
      tick(); run_exp("stall_hold", 98, 32'h0000_3002);
    end
    stall = 1'b0; cond = 4'h0;
    tick(); run_exp("stall_release", 99, 32'h0003_8003);
    opword_opcode = 6'd5;
    tick(); run_exp("op5_c0", 160, 32'h0000_5000);
    for (int c = 1; c < 32; c++) tick();
    run_exp("op5_c31", 191, 32'h0000_501F);
    tick();
    chk("fault_enter", {18'h0, uaddr, out, booted, fault}, {18'h0, 12'd191, 32'h0, 1'b1, 1'b1});
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("fault_hold", {18'h0, uaddr, out, booted, fault}, {18'h0, 12'd191, 32'h0, 1'b1, 1'b1});
    end
    do_reset();
    chk("fault_reset", {18'h0, uaddr, out, booted, fault}, 64'h0);
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    run_exp("store_retained", 0, 32'h0203_8000);

    // Partial word: three bytes then done; boot strobes in RUN must not write.
    do_reset();
    foreach (tbl[i]) ;
    boot_we = 1'b1;
    boot_data = 8'hAA; tick();
    boot_data = 8'hBB; tick();
    boot_data = 8'hCC; tick();
    boot_we = 1'b0;
    chk("partial_pre_done", {30'h0, out, booted, fault}, 64'h0);
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    run_exp("partial_word", 0, 32'h00CC_BBAA);
    boot_data = 8'hFF; boot_we = 1'b1;
    for (int s = 0; s < 4; s++) tick();
    boot_done = 1'b1; tick();
    boot_we = 1'b0; boot_done = 1'b0;
    run_exp("run_ignores_boot", 5, 32'h0);
    do_reset();
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    run_exp("partial_retained", 0, 32'h00CC_BBAA);
    tick(); run_exp("no_write_in_run", 1, 32'h0);

    // Random phase: full random image, then randomized run against the model.
    do_reset();
    for (int a = 0; a < 4096; a++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom % 4 != 0) w[17] = 1'b0;
      boot_word(w, 1'b1);
    end
    boot_done = 1'b1; cycle(); boot_done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      chk("rand", {18'h0, uaddr, out, booted, fault},
          {18'h0, m_uaddr(), m_out(), 1'(m_mode != 0), 1'(m_mode == 2)});
      stall         = ($urandom % 4 == 0);
      cond          = 4'($urandom);
      bus_opcode    = 6'($urandom);
      opword_opcode = 6'($urandom);
      boot_data     = 8'($urandom);
      boot_we       = (m_mode != 0) && ($urandom % 16 == 0);
      boot_done     = ($urandom % 32 == 0);
      rst           = (m_mode == 2) ? ($urandom % 8 == 0) : ($urandom % 400 == 0);
      cycle();
    end
    rst = 1'b0; boot_we = 1'b0; boot_done = 1'b0; stall = 1'b0;
    chk("rand_final", {18'h0, uaddr, out, booted, fault},
        {18'h0, m_uaddr(), m_out(), 1'(m_mode != 0), 1'(m_mode == 2)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised successor to the fixed microcode lookup.
- Combines a writable control store, loaded byte-serially at boot, with the sequencing state that the lookup's address inputs imply: opcode register, micro-op counter and latched condition bit.
- Sits between the bus/opword register and control_logic and drives the per-cycle control word.
- Adds stall, overflow fault detection and a selectable number of condition inputs.

Parameters:
- OPCODE_BITS, 6, opcode register width.
- UOP_BITS, 5, micro-op counter width.
- WORD_WIDTH, 32, control word width; must be a multiple of BOOT_WIDTH.
- BOOT_WIDTH, 8, bootstrap data width.
- NUM_COND, 4, condition inputs; selector width CSEL_BITS = clog2(NUM_COND).
- RST_BIT, 17, control word bit meaning "reset micro-op counter".
- INPLANE_LSB, 14, LSB of 3-bit in_plane field.
- IN_OPCODE, 6, in_plane value meaning "load opcode".
- OPSEL_BIT, 25, opcode source select: 0 = opword, 1 = bus.
- CSEL_LSB, 26, LSB of the condition select field.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- STALL  in  1  hold all sequencing state this cycle.
- OPWORD_OPCODE  in  OPCODE_BITS  opcode field of the opword register.
- BUS_OPCODE  in  OPCODE_BITS  low bits of the bus.
- COND  in  NUM_COND  condition sources (MLU zero/carry/negative, interrupt).
- BOOT_WE  in  1  bootstrap byte strobe.
- BOOT_DATA  in  BOOT_WIDTH  bootstrap data.
- BOOT_DONE  in  1  end-of-bootstrap pulse.
- OUT  out  WORD_WIDTH  current control word.
- UADDR  out  1+OPCODE_BITS+UOP_BITS  {cond, opcode, count}, for trace.
- BOOTED  out  1  control store valid, sequencing active.
- FAULT  out  1  micro-op counter overflow.

Behaviour:
- Store depth is DEPTH = 2^(1+OPCODE_BITS+UOP_BITS) words. The store is not cleared by RST.
- States are BOOT, RUN and FAULT. RST forces BOOT and clears: boot address, lane counter, assembly register, opcode, count, cond. On reset, OUT=0, BOOTED=0 and FAULT=0.
- BOOT:
  - OUT=0.
  - Each BOOT_WE cycle shifts BOOT_DATA into lane L = lane counter, LSB lane first.
  - On the last lane (WORD_WIDTH/BOOT_WIDTH - 1), the assembled word is written to store[boot address]. Boot address then increments and wraps at DEPTH to 0; the lane counter returns to 0.
  - BOOT_DONE with lane counter != 0 writes the partial word with unfilled lanes zero before leaving.
  - BOOT_DONE and BOOT_WE in the same cycle: the byte is taken first, then the done handling.
  - BOOT_DONE moves to RUN with opcode=0 (reset op), count=0, cond=0.
- RUN:
  - BOOTED=1.
  - OUT = store[UADDR] combinationally, within the same cycle as the state change, with zero added latency.
  - BOOT_WE and BOOT_DONE are ignored.
  - On each CLK edge with STALL=0, with W = OUT:
    - count <= W[RST_BIT] ? 0 : count+1.
    - If W[INPLANE_LSB+:3] == IN_OPCODE: opcode <= W[OPSEL_BIT] ? BUS_OPCODE : OPWORD_OPCODE.
    - cond <= COND[W[CSEL_LSB+:CSEL_BITS]]. This is sampled every edge, so cond always reflects the select of the previous micro-op.
    - A select value >= NUM_COND yields cond=0.
  - STALL=1: opcode, count and cond hold; OUT stays stable.
  - Overflow: count == 2^UOP_BITS-1 with W[RST_BIT]=0 and STALL=0 moves to FAULT instead of wrapping.
- FAULT:
  - OUT=0, FAULT=1, BOOTED=1.
  - UADDR frozen at the faulting address.
  - Only RST exits.
- RST asserted mid-boot or mid-instruction aborts immediately. Previously written store words are retained; the boot address restarts at 0 for the next load.

Test Plan:
- Reset then 4 BOOT_WE bytes 0x01,0x00,0x00,0x00 -> store[0]=0x00000001; boot address becomes 1; OUT=0 and BOOTED=0 throughout.
- Boot a fetch sequence (op 1, count 0..4, last word has in_plane=6, opsel=0, RST_BIT=1), then BOOT_DONE and OPWORD_OPCODE=3:
  - op 0 count 0 runs reset; its GO_FETCH loads 1 from the bus.
  - After fetch, UADDR={0,3,0}, count=0.
- BEQ with cond select 0 and COND[0]=1 on micro-op 2 -> micro-op 3 reads address with bit 11 set. With COND[0]=0, bit 11 is clear.
- STALL held 3 cycles during count=2 -> OUT and UADDR unchanged for 3 cycles; count=3 one edge after release.
- Opcode whose words never set RST_BIT -> after 32 micro-ops FAULT=1, OUT=0, UADDR count=31; RST then returns BOOTED=0 with the store contents retained.
- 3 bytes then BOOT_DONE -> word written with the top byte 0; state RUN; a subsequent BOOT_WE has no effect.
